// File: rtl/mem_req_master.sv
// Command front end for the handshaked single-port memory: queues client commands,
// issues one access at a time on valid/ready and returns one response per command,
// flagging accesses that the memory never acknowledged within TIMEOUT wait cycles.
module mem_req_master #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CMD_DEPTH  = 2,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // client command side
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [WIDTH-1:0]      cmd_wdata_i,
    // client response side
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [WIDTH-1:0]      rsp_rdata_o,
    output logic                  rsp_wr_o,
    output logic                  rsp_err_o,
    // memory side
    output logic                  mem_valid_o,
    output logic                  mem_wr_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [WIDTH-1:0]      mem_rdata_i
);

    localparam int unsigned PtrW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(CMD_DEPTH + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StRsp} state_e;

    // Command FIFO storage and bookkeeping
    logic                  fifo_wr_q    [CMD_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q  [CMD_DEPTH];
    logic [WIDTH-1:0]      fifo_wdata_q [CMD_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q, count_d;
    logic                  cmd_ready_q;
    logic                  fifo_empty;
    logic                  push, pop;

    // FSM state and registered outputs
    state_e                state_q;
    logic [TmoW-1:0]       tmo_q;
    logic                  mem_valid_q;
    logic                  mem_wr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0]      mem_wdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_wr_q;
    logic                  rsp_err_q;
    logic [WIDTH-1:0]      rsp_rdata_q;

    assign fifo_empty = (count_q == '0);
    assign push       = cmd_valid_i && cmd_ready_q;
    // The head leaves the FIFO whenever the FSM moves into ISSUE.
    assign pop        = !fifo_empty &&
                        ((state_q == StIdle) || ((state_q == StRsp) && rsp_ready_i));

    // Occupancy next state; a simultaneous push and pop cancel out
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // FIFO payload storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_wr_q[wr_ptr_q]    <= cmd_wr_i;
            fifo_addr_q[wr_ptr_q]  <= cmd_addr_i;
            fifo_wdata_q[wr_ptr_q] <= cmd_wdata_i;
        end
    end

    // FIFO pointers, count and registered ready (held low during reset)
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q     <= count_d;
            cmd_ready_q <= (count_d != CntW'(CMD_DEPTH));
        end
    end

    // Access sequencing: IDLE -> ISSUE -> WAIT -> RSP, all outputs registered
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            tmo_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        mem_valid_q <= 1'b1;
                        mem_wr_q    <= fifo_wr_q[rd_ptr_q];
                        mem_addr_q  <= fifo_addr_q[rd_ptr_q];
                        mem_wdata_q <= fifo_wdata_q[rd_ptr_q];
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    // mem_ready_i may still be high from the previous access; ignore it.
                    tmo_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (mem_ready_i) begin
                        rsp_rdata_q <= mem_wr_q ? '0 : mem_rdata_i;
                        rsp_wr_q    <= mem_wr_q;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        mem_valid_q <= 1'b0;
                        state_q     <= StRsp;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                        if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                            rsp_rdata_q <= '0;
                            rsp_wr_q    <= mem_wr_q;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            mem_valid_q <= 1'b0;
                            state_q     <= StRsp;
                        end
                    end
                end
                StRsp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        if (pop) begin
                            mem_valid_q <= 1'b1;
                            mem_wr_q    <= fifo_wr_q[rd_ptr_q];
                            mem_addr_q  <= fifo_addr_q[rd_ptr_q];
                            mem_wdata_q <= fifo_wdata_q[rd_ptr_q];
                            state_q     <= StIssue;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_ready_o    = cmd_ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_wr_o       = rsp_wr_q;
    assign rsp_err_o      = rsp_err_q;
    assign mem_valid_o    = mem_valid_q;
    assign mem_wr_rd_en_o = mem_wr_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;

endmodule
